multiplexer: RTL and testbench
==============================

MULTIPLEXER -- requirements
Module: multiplexer

Interface
REQ-001 Parameter WIDTH, default 1: bit width of data inputs a, b and outputs o, o_q.
REQ-002 Parameter CNT_W, default 16: width of switch_count.
REQ-003 Port clk  input  1: single clock; all sequential logic on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port a  input  WIDTH: data input 0.
REQ-006 Port b  input  WIDTH: data input 1.
REQ-007 Port sel  input  1: select; 0 picks a, 1 picks b.
REQ-008 Port o  output  WIDTH: combinational mux result.
REQ-009 Port o_q  output  WIDTH: registered copy of o.
REQ-010 Port sel_q  output  1: registered copy of sel.
REQ-011 Port switch_count  output  CNT_W: count of sel transitions since reset.

Function
REQ-012 o SHALL equal a when sel=0 and b when sel=1, purely combinational, zero latency, independent of clk and rst.
REQ-013 o SHALL be valid with clk held constant or unconnected; the combinational path requires no clock edge.
REQ-014 o SHALL respond to changes of a, b or sel within the same delta/time step, for every bit independently.
REQ-015 o_q SHALL load o on each rising clk edge when rst=0: one-cycle latency.
REQ-016 sel_q SHALL load sel on each rising clk edge when rst=0.
REQ-017 A sel transition SHALL be detected as sel != sel_q at a rising edge with rst=0; switch_count increments by 1 on each detection.
REQ-018 switch_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 Changes on a or b alone SHALL NOT affect switch_count.
REQ-020 The first edge after reset release SHALL count a transition if sel=1, because sel_q resets to 0.
REQ-021 A sel pulse shorter than one clock period SHALL appear on o but need not be counted.

Reset
REQ-022 On a rising edge with rst=1: o_q, sel_q and switch_count SHALL all become 0.
REQ-023 rst SHALL have priority over counting and loading when both apply on the same edge.
REQ-024 rst SHALL NOT affect o; o keeps following a/b/sel during reset.
REQ-025 Asserting rst mid-operation SHALL clear the state on the next edge, with no other side effects.

Structure
REQ-026 The default widths and the select encoding constants (SEL_A=0, SEL_B=1) SHALL go in a shared package, mux_pkg.
REQ-027 The combinational selector SHALL be a sub-module, mux2_comb, with ports a, b, sel and o.
REQ-028 Registers and the counter SHALL sit in the top module only, with no latches and no internal clock gating.

Verification
REQ-029 Hold clk idle and drive a=0, b=0, sel=0 -> o=0; then a=0, b=1, sel=0 -> o=0.
REQ-030 With b=1 and a=0, set sel=1 -> o=1; then a=1, sel=1 -> o=1; then sel=0, a=1 -> o=1; then a=0 -> o=0.
REQ-031 Clocked with WIDTH=8, a=0x5A, b=0xA5, toggle sel each cycle -> o_q lags o by one cycle and switch_count increments once per toggle.
REQ-032 Hold rst=1 for 2 edges while toggling sel -> o_q=0, sel_q=0, switch_count=0, and o still tracks sel.
REQ-033 With CNT_W=2, toggle sel 6 times -> switch_count saturates at 3.
REQ-034 Hold sel=1 and randomize a and b for 10 cycles -> switch_count unchanged after the first edge and o=b every cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the multiplexer block: default widths and select encoding.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/multiplexer_if.sv
// Bundle of the multiplexer data/select inputs and its registered observation outputs.
interface multiplexer_if
  import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_q;
    logic             sel_q;
    logic [CNT_W-1:0] switch_count;

    // There is no handshake: inputs are level signals, sampled on every rising clk edge.
    modport master (output a, b, sel, input o, o_q, sel_q, switch_count);
    modport slave  (input a, b, sel, output o, o_q, sel_q, switch_count);

endinterface

// File: rtl/mux2_comb.sv
// Purely combinational 2:1 selector; no clock, no state.
module mux2_comb
  import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    assign o = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/multiplexer.sv
// 2:1 mux with a registered copy of the result and select, plus a saturating
// counter of select transitions seen at clock edges.
module multiplexer
  import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] switch_count
);

    logic [WIDTH-1:0] o_q_q;
    logic [WIDTH-1:0] o_q_d;
    logic             sel_q_q;
    logic             sel_q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_changed;

    mux2_comb #(
        .WIDTH(WIDTH)
    ) u_mux2_comb (
        .a  (a),
        .b  (b),
        .sel(sel),
        .o  (o)
    );

    // sel_q resets to SEL_A, so a high sel on the first edge after reset counts.
    assign sel_changed = (sel != sel_q_q);

    always_comb begin
        o_q_d   = o;
        sel_q_d = sel;
        cnt_d   = cnt_q;
        if (sel_changed && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q_q   <= '0;
            sel_q_q <= SEL_A;
            cnt_q   <= '0;
        end else begin
            o_q_q   <= o_q_d;
            sel_q_q <= sel_q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_q          = o_q_q;
    assign sel_q        = sel_q_q;
    assign switch_count = cnt_q;

endmodule

// File: tb/tb_multiplexer.sv
// Bench for multiplexer: two instances (16-bit and 2-bit counter) share stimulus
// and are checked against a history-based reference model.
module tb_multiplexer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b0;

    int tests = 0;
    int fails = 0;

    multiplexer_if #(.WIDTH(W), .CNT_W(16)) bus0 ();
    multiplexer_if #(.WIDTH(W), .CNT_W(2))  bus1 ();

    // model state: sampled sel history since reset and registered-output queue
    logic         sel_hist[$];
    logic [W-1:0] exp_q[$];

    always #5 clk = clk_run ? ~clk : clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    multiplexer #(.WIDTH(W), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .a(bus0.a), .b(bus0.b), .sel(bus0.sel),
        .o(bus0.o), .o_q(bus0.o_q), .sel_q(bus0.sel_q),
        .switch_count(bus0.switch_count)
    );

    multiplexer #(.WIDTH(W), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .a(bus0.a), .b(bus0.b), .sel(bus0.sel),
        .o(bus1.o), .o_q(bus1.o_q), .sel_q(bus1.sel_q),
        .switch_count(bus1.switch_count)
    );

    assign bus1.a   = bus0.a;
    assign bus1.b   = bus0.b;
    assign bus1.sel = bus0.sel;

    function automatic logic [W-1:0] ref_mux(logic [W-1:0] a, logic [W-1:0] b, logic s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = s ? b[i] : a[i];
        return r;
    endfunction

    function automatic int transitions();
        int n = 0;
        for (int i = 1; i < sel_hist.size(); i++)
            if (sel_hist[i] != sel_hist[i-1]) n++;
        return n;
    endfunction

    function automatic int sat(int n, int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic s);
        bus0.a   = a;
        bus0.b   = b;
        bus0.sel = s;
        #1;
    endtask

    // advance one clock edge and record what the registers should capture
    task automatic step();
        @(posedge clk);
        if (rst) begin
            sel_hist = {1'b0};
            exp_q    = {8'h00};
        end else begin
            sel_hist.push_back(bus0.sel);
            exp_q.push_back(ref_mux(bus0.a, bus0.b, bus0.sel));
        end
        @(negedge clk);
    endtask

    task automatic test_comb_idle();
        logic [W-1:0] ra, rb;
        logic rs;
        drive(8'h00, 8'h00, 1'b0);
        tests++; if (bus0.o !== 8'h00) begin fails++; $display("FAIL idle_a0b0s0 o=%h exp=%h", bus0.o, 8'h00); end
        drive(8'h00, 8'h01, 1'b0);
        tests++; if (bus0.o !== 8'h00) begin fails++; $display("FAIL idle_a0b1s0 o=%h exp=%h", bus0.o, 8'h00); end
        drive(8'h00, 8'h01, 1'b1);
        tests++; if (bus0.o !== 8'h01) begin fails++; $display("FAIL idle_a0b1s1 o=%h exp=%h", bus0.o, 8'h01); end
        drive(8'h01, 8'h01, 1'b1);
        tests++; if (bus0.o !== 8'h01) begin fails++; $display("FAIL idle_a1b1s1 o=%h exp=%h", bus0.o, 8'h01); end
        drive(8'h01, 8'h01, 1'b0);
        tests++; if (bus0.o !== 8'h01) begin fails++; $display("FAIL idle_a1s0 o=%h exp=%h", bus0.o, 8'h01); end
        drive(8'h00, 8'h01, 1'b0);
        tests++; if (bus0.o !== 8'h00) begin fails++; $display("FAIL idle_a0s0 o=%h exp=%h", bus0.o, 8'h00); end
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            drive(ra, rb, rs);
            tests++;
            if (bus0.o !== ref_mux(ra, rb, rs)) begin
                fails++; $display("FAIL idle_rand o=%h exp=%h", bus0.o, ref_mux(ra, rb, rs));
            end
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            drive(ra, rb, ~bus0.sel);
            tests++;
            if (bus0.o !== ref_mux(ra, rb, bus0.sel)) begin
                fails++; $display("FAIL reset_o_tracks o=%h exp=%h", bus0.o, ref_mux(ra, rb, bus0.sel));
            end
            step();
        end
        tests++; if (bus0.o_q !== 8'h00) begin fails++; $display("FAIL reset_o_q o_q=%h exp=00", bus0.o_q); end
        tests++; if (bus0.sel_q !== 1'b0) begin fails++; $display("FAIL reset_sel_q sel_q=%b exp=0", bus0.sel_q); end
        tests++; if (bus0.switch_count !== 16'd0) begin fails++; $display("FAIL reset_count cnt=%0d exp=0", bus0.switch_count); end
        tests++; if (bus1.switch_count !== 2'd0) begin fails++; $display("FAIL reset_count2 cnt=%0d exp=0", bus1.switch_count); end
        rst = 1'b0;
    endtask

    task automatic check_regs(string name);
        tests++;
        if (bus0.o_q !== exp_q[$]) begin
            fails++; $display("FAIL %s_o_q o_q=%h exp=%h", name, bus0.o_q, exp_q[$]);
        end
        tests++;
        if (bus0.sel_q !== sel_hist[$]) begin
            fails++; $display("FAIL %s_sel_q sel_q=%b exp=%b", name, bus0.sel_q, sel_hist[$]);
        end
        tests++;
        if (bus0.switch_count !== 16'(sat(transitions(), 16))) begin
            fails++; $display("FAIL %s_count cnt=%0d exp=%0d", name, bus0.switch_count, sat(transitions(), 16));
        end
        tests++;
        if (bus1.switch_count !== 2'(sat(transitions(), 2))) begin
            fails++; $display("FAIL %s_count2 cnt=%0d exp=%0d", name, bus1.switch_count, sat(transitions(), 2));
        end
    endtask

    task automatic test_toggle();
        logic [W-1:0] prev_o;
        drive(8'h5A, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            prev_o = bus0.o;
            tests++;
            if (prev_o !== ref_mux(8'h5A, 8'hA5, bus0.sel)) begin
                fails++; $display("FAIL toggle_o o=%h exp=%h", prev_o, ref_mux(8'h5A, 8'hA5, bus0.sel));
            end
            step();
            check_regs("toggle");
            tests++;
            if (bus0.switch_count !== 16'(i + 1)) begin
                fails++; $display("FAIL toggle_step cnt=%0d exp=%0d", bus0.switch_count, i + 1);
            end
            drive(8'h5A, 8'hA5, ~bus0.sel);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; step(); rst = 1'b0;
        drive(8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(8'h00, 8'hFF, ~bus0.sel);
            step();
        end
        tests++; if (bus1.switch_count !== 2'd3) begin fails++; $display("FAIL saturate_cnt2 cnt=%0d exp=3", bus1.switch_count); end
        tests++; if (bus0.switch_count !== 16'd6) begin fails++; $display("FAIL saturate_cnt16 cnt=%0d exp=6", bus0.switch_count); end
        check_regs("saturate");
    endtask

    task automatic test_hold_sel();
        logic [W-1:0] ra, rb;
        logic [15:0] held;
        drive(W'($urandom), W'($urandom), 1'b1);
        step();
        held = 16'(sat(transitions(), 16));
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            drive(ra, rb, 1'b1);
            tests++; if (bus0.o !== rb) begin fails++; $display("FAIL hold_o o=%h exp=%h", bus0.o, rb); end
            step();
            tests++;
            if (bus0.switch_count !== held) begin
                fails++; $display("FAIL hold_count cnt=%0d exp=%0d", bus0.switch_count, held);
            end
            check_regs("hold");
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom));
            step();
        end
        rst = 1'b1;
        drive(8'h33, 8'hCC, ~bus0.sel);
        step();
        rst = 1'b0;
        tests++; if (bus0.switch_count !== 16'd0) begin fails++; $display("FAIL midrst_count cnt=%0d exp=0", bus0.switch_count); end
        tests++; if (bus0.o_q !== 8'h00) begin fails++; $display("FAIL midrst_o_q o_q=%h exp=00", bus0.o_q); end
        drive(8'h33, 8'hCC, 1'b1);
        step();
        tests++; if (bus0.switch_count !== 16'd1) begin fails++; $display("FAIL first_edge_count cnt=%0d exp=1", bus0.switch_count); end
        check_regs("first_edge");
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? ~bus0.sel : bus0.sel);
            tests++;
            if (bus0.o !== ref_mux(bus0.a, bus0.b, bus0.sel)) begin
                fails++; $display("FAIL rand_o o=%h exp=%h", bus0.o, ref_mux(bus0.a, bus0.b, bus0.sel));
            end
            step();
            check_regs("rand");
        end
    endtask

    initial begin
        sel_hist = {1'b0};
        exp_q    = {8'h00};
        bus0.a = '0; bus0.b = '0; bus0.sel = 1'b0;
        test_comb_idle();
        clk_run = 1'b1;
        @(negedge clk);
        test_reset();
        test_toggle();
        test_saturate();
        test_hold_sel();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
